// File: rtl/rpm_edge_meter.sv
// Multi-channel tachometer front end: synchroniser, glitch filter, edge pulse
// generator and saturating period meter with stall detection per channel.
module rpm_edge_meter #(
    parameter int CH          = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int PER_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         rpm,
    input  logic [2*CH-1:0]       mode,
    input  logic [FILT_W-1:0]     filt_len,
    output logic [CH-1:0]         level,
    output logic [CH-1:0]         edge_pulse,
    output logic [CH*PER_W-1:0]   period,
    output logic [CH-1:0]         period_valid,
    output logic [CH-1:0]         timeout
);

    localparam logic [PER_W-1:0] PER_MAX = '1;

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync_s;
        logic                   level_q, level_d;
        logic [FILT_W-1:0]      fcnt_q, fcnt_d;
        logic                   edge_q, edge_d;
        logic [1:0]             mode_ch;
        logic                   rise, fall;
        logic [PER_W-1:0]       per_cnt_q, per_cnt_d;
        logic [PER_W-1:0]       period_q, period_d;
        logic                   valid_q, valid_d;
        logic                   timeout_q, timeout_d;
        logic                   armed_q, armed_d;
        logic                   sat;

        assign sync_s  = sync_q[SYNC_STAGES-1];
        assign mode_ch = mode[2*gi +: 2];

        // Sync chain resets to 1 so an idle-high sensor produces no edge on release.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= '1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], rpm[gi]};
            end
        end

        always_comb begin
            level_d = level_q;
            fcnt_d  = fcnt_q;
            if (sync_s == level_q) begin
                fcnt_d = '0;
            end else if (fcnt_q == filt_len) begin
                level_d = sync_s;
                fcnt_d  = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        // The pulse is decided from the filter's next state so it lines up with the level change.
        always_comb begin
            rise = ~level_q & level_d;
            fall = level_q & ~level_d;
            case (mode_ch)
                2'b01:   edge_d = rise;
                2'b10:   edge_d = fall;
                2'b11:   edge_d = rise | fall;
                default: edge_d = 1'b0;
            endcase
        end

        always_comb begin
            sat       = (per_cnt_q == PER_MAX);
            per_cnt_d = per_cnt_q;
            period_d  = period_q;
            valid_d   = 1'b0;
            timeout_d = timeout_q;
            armed_d   = armed_q;
            if (edge_q) begin
                per_cnt_d = '0;
                if (armed_q && !sat) begin
                    period_d = per_cnt_q + 1'b1;
                    valid_d  = 1'b1;
                end
                armed_d   = 1'b1;
                timeout_d = 1'b0;
            end else if (!sat) begin
                per_cnt_d = per_cnt_q + 1'b1;
            end else begin
                timeout_d = 1'b1;
                armed_d   = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                level_q   <= 1'b1;
                fcnt_q    <= '0;
                edge_q    <= 1'b0;
                per_cnt_q <= '0;
                period_q  <= '0;
                valid_q   <= 1'b0;
                timeout_q <= 1'b0;
                armed_q   <= 1'b0;
            end else begin
                level_q   <= level_d;
                fcnt_q    <= fcnt_d;
                edge_q    <= edge_d;
                per_cnt_q <= per_cnt_d;
                period_q  <= period_d;
                valid_q   <= valid_d;
                timeout_q <= timeout_d;
                armed_q   <= armed_d;
            end
        end

        assign level[gi]                 = level_q;
        assign edge_pulse[gi]            = edge_q;
        assign period[PER_W*gi +: PER_W] = period_q;
        assign period_valid[gi]          = valid_q;
        assign timeout[gi]               = timeout_q;

    end

endmodule

// File: tb/tb_rpm_edge_meter.sv
// Directed self-checking bench for rpm_edge_meter (CH=2, SYNC=2, FILT_W=4, PER_W=8).
module tb_rpm_edge_meter;

    localparam int CH    = 2;
    localparam int SYNC  = 2;
    localparam int FW    = 4;
    localparam int PW    = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   rpm;
    logic [2*CH-1:0] mode;
    logic [FW-1:0]   filt_len;
    logic [CH-1:0]   level;
    logic [CH-1:0]   edge_pulse;
    logic [CH*PW-1:0] period;
    logic [CH-1:0]   period_valid;
    logic [CH-1:0]   timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rpm_edge_meter #(
        .CH(CH), .SYNC_STAGES(SYNC), .FILT_W(FW), .PER_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .rpm(rpm), .mode(mode), .filt_len(filt_len),
        .level(level), .edge_pulse(edge_pulse), .period(period),
        .period_valid(period_valid), .timeout(timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [CH-1:0] r, input int cycles);
        rpm = r;
        repeat (cycles) @(negedge clk);
    endtask

    // Returns the number of negedges until edge_pulse[ch] is seen, or -1 on expiry.
    task automatic waitPulse(input int ch, input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (edge_pulse[ch] === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int pulses, cyc, p1, v1, bad, idle0, ph1, ph2, tcyc;
        logic prev1;

        // Reset with rpm toggling
        rst = 1'b0; rpm = 2'b00; mode = 4'b0000; filt_len = 4'd0;
        repeat (4) begin
            @(negedge clk);
            rpm = ~rpm;
        end
        checkOutput("rst_level",   32'(level),        32'd3);
        checkOutput("rst_pulse",   32'(edge_pulse),   32'd0);
        checkOutput("rst_period",  32'(period),       32'd0);
        checkOutput("rst_valid",   32'(period_valid), 32'd0);
        checkOutput("rst_timeout", 32'(timeout),      32'd0);

        rpm = 2'b11;
        @(negedge clk);
        rst = 1'b1; mode = 4'b1111;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (edge_pulse != 2'b00) pulses++;
        end
        checkOutput("rel_no_pulse", 32'(pulses), 32'd0);
        checkOutput("rel_level",    32'(level),  32'd3);

        // Filter, F=3
        mode = 4'b0001; filt_len = 4'd3;
        applyStimulus(2'b10, 20);
        checkOutput("filt_low", 32'(level), 32'd2);
        applyStimulus(2'b11, 3);
        rpm = 2'b10;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (edge_pulse[0]) pulses++;
        end
        checkOutput("glitch_pulse", 32'(pulses), 32'd0);
        checkOutput("glitch_level", 32'(level),  32'd2);
        rpm = 2'b11;
        waitPulse(0, 20, cyc);
        checkOutput("filt_latency", 32'(cyc), 32'd6);
        @(negedge clk);
        checkOutput("filt_one_cycle", 32'(edge_pulse[0]),   32'd0);
        checkOutput("filt_arm_only",  32'(period_valid[0]), 32'd0);
        checkOutput("filt_high",      32'(level),           32'd3);

        // Rising period on ch1, square wave of 20
        filt_len = 4'd0; mode = 4'b0101;
        p1 = 0; v1 = 0; bad = 0; idle0 = 0; prev1 = 1'b0;
        for (int c = 0; c < 110; c++) begin
            rpm[1] = ((c % 20) >= 10);
            @(negedge clk);
            if (edge_pulse[1]) p1++;
            if (period_valid[1]) begin
                v1++;
                checkOutput("t3_period", 32'(period[PW +: PW]), 32'd20);
                if (!prev1) bad++;
            end
            prev1 = edge_pulse[1];
            if (edge_pulse[0] || period_valid[0]) idle0++;
        end
        checkOutput("t3_pulses",   32'(p1),    32'd5);
        checkOutput("t3_strobes",  32'(v1),    32'd4);
        checkOutput("t3_strobe_follows_pulse", 32'(bad), 32'd0);
        checkOutput("t3_ch0_idle", 32'(idle0), 32'd0);

        // Both edges on ch0 (7 high / 13 low), then falling-only
        mode = 4'b0111;
        ph1 = 0; ph2 = 0;
        for (int c = 0; c < 140; c++) begin
            if (c == 72) mode = 4'b0110;
            rpm[0] = ((c % 20) < 7);
            @(negedge clk);
            if (period_valid[0]) begin
                if (c >= 80) begin
                    ph2++;
                    checkOutput("t4_fall_period", 32'(period[PW-1:0]), 32'd20);
                end else if (c >= 15) begin
                    ph1++;
                    checkOutput("t4_both_period", 32'(period[PW-1:0]), ((c % 20) == 3) ? 32'd13 : 32'd7);
                end
            end
        end
        checkOutput("t4_both_strobes", 32'(ph1), 32'd6);
        checkOutput("t4_fall_strobes", 32'(ph2), 32'd3);

        // Timeout on ch0
        mode = 4'b0101; rpm[0] = 1'b1;
        waitPulse(0, 20, cyc);
        checkOutput("t5_rise_latency", 32'(cyc), 32'd3);
        tcyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (timeout[0]) begin
                tcyc = i;
                break;
            end
        end
        checkOutput("t5_timeout_delay", 32'(tcyc), 32'd257);
        rpm[0] = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("t5_timeout_held", 32'(timeout[0]), 32'd1);
        rpm[0] = 1'b1;
        waitPulse(0, 20, cyc);
        checkOutput("t5_rearm_latency", 32'(cyc), 32'd3);
        for (int j = 1; j <= 31; j++) begin
            @(negedge clk);
            if (j == 1) begin
                checkOutput("t5_timeout_clear", 32'(timeout[0]),      32'd0);
                checkOutput("t5_rearm_nostrobe", 32'(period_valid[0]), 32'd0);
                checkOutput("t5_period_hold",   32'(period[PW-1:0]),  32'd13);
                rpm[0] = 1'b0;
            end
            if (j == 27) rpm[0] = 1'b1;
            if (j == 30) checkOutput("t5_pulse30", 32'(edge_pulse[0]), 32'd1);
            if (j == 31) begin
                checkOutput("t5_valid30",  32'(period_valid[0]), 32'd1);
                checkOutput("t5_period30", 32'(period[PW-1:0]),  32'd30);
            end
        end

        // Reset mid-measurement
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t6_level",   32'(level),        32'd3);
        checkOutput("t6_pulse",   32'(edge_pulse),   32'd0);
        checkOutput("t6_period",  32'(period),       32'd0);
        checkOutput("t6_valid",   32'(period_valid), 32'd0);
        checkOutput("t6_timeout", 32'(timeout),      32'd0);
        rpm = 2'b11; mode = 4'b0001;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        applyStimulus(2'b10, 10);
        rpm = 2'b11;
        waitPulse(0, 20, cyc);
        checkOutput("t6_first_latency", 32'(cyc), 32'd3);
        for (int j = 1; j <= 21; j++) begin
            @(negedge clk);
            if (j == 1) begin
                checkOutput("t6_arm_only", 32'(period_valid[0]), 32'd0);
                rpm = 2'b10;
            end
            if (j == 17) rpm = 2'b11;
            if (j == 20) checkOutput("t6_pulse20", 32'(edge_pulse[0]), 32'd1);
            if (j == 21) begin
                checkOutput("t6_valid20",  32'(period_valid[0]), 32'd1);
                checkOutput("t6_period20", 32'(period[PW-1:0]),  32'd20);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
